// File: rtl/progloader_axi_burst.sv
// progloader_axi_burst
// Receives a framed byte stream (address, word count, N data words, checksum; all fields LSB
// byte first) and writes each assembled word to memory over an AXI4-Lite write channel.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   en, hold                 loader enable; core busy (blocks only the start of a new frame)
//   in_valid, in_byte        one-cycle byte strobe from the UART receiver
//   axi_aw*/axi_w*/axi_b*    AXI4-Lite write address, write data and write response channels
//   busy, done               not-idle flag; one-cycle end-of-frame pulse
//   err_resp/csum/ovr/abort  sticky status flags, cleared when a new frame starts
//   words_written            words written in the current or last frame
module progloader_axi_burst #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_BYTES  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    hold,
    input  logic                    in_valid,
    input  logic [7:0]              in_byte,
    output logic [ADDR_W-1:0]       axi_awaddr,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,
    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,
    output logic                    axi_bready,
    input  logic                    axi_bvalid,
    input  logic [1:0]              axi_bresp,
    output logic                    busy,
    output logic                    done,
    output logic                    err_resp,
    output logic                    err_csum,
    output logic                    err_ovr,
    output logic                    err_abort,
    output logic [31:0]             words_written
);

    localparam int unsigned LEN_W = LEN_BYTES * 8;
    localparam logic [7:0] ADDR_LAST = 8'(ADDR_W / 8 - 1);
    localparam logic [7:0] LEN_LAST  = 8'(LEN_BYTES - 1);
    localparam logic [7:0] DATA_LAST = 8'(DATA_WIDTH / 8 - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_WIDTH / 8);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);

    typedef enum logic [2:0] {
        StIdle, StAddr, StLen, StData, StWrite, StResp, StCsum, StDone
    } state_t;

    state_t                  state;
    logic [7:0]              byte_cnt;
    logic [LEN_W-1:0]        remaining;
    logic [DATA_WIDTH-1:0]   data_sr;
    logic [7:0]              sum;
    logic                    aw_done;
    logic                    w_done;
    logic                    abort_pend;

    logic [ADDR_W-1:0]       addr_shift;
    logic [LEN_W-1:0]        len_shift;
    logic [DATA_WIDTH-1:0]   data_shift;
    logic [7:0]              sum_next;
    logic [LEN_W-1:0]        rem_dec;
    logic                    aw_ok;
    logic                    w_ok;

    // Fields arrive LSB byte first: each new byte enters at the top and the register shifts
    // down, so after the last byte the value is in natural order.
    always_comb begin
        addr_shift = (axi_awaddr >> 8) | (ADDR_W'(in_byte) << (ADDR_W - 8));
        len_shift  = (remaining >> 8) | (LEN_W'(in_byte) << (LEN_W - 8));
        data_shift = (data_sr >> 8) | (DATA_WIDTH'(in_byte) << (DATA_WIDTH - 8));
        sum_next   = sum + in_byte;
        rem_dec    = remaining - LEN_ONE;
        // A channel counts as complete if it finished earlier or handshakes this cycle.
        aw_ok      = aw_done | (axi_awvalid & axi_awready);
        w_ok       = w_done | (axi_wvalid & axi_wready);
    end

    assign axi_wstrb = '1;
    assign busy      = (state != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            byte_cnt      <= '0;
            remaining     <= '0;
            data_sr       <= '0;
            sum           <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            abort_pend    <= 1'b0;
            axi_awaddr    <= '0;
            axi_awvalid   <= 1'b0;
            axi_wdata     <= '0;
            axi_wvalid    <= 1'b0;
            axi_bready    <= 1'b0;
            done          <= 1'b0;
            err_resp      <= 1'b0;
            err_csum      <= 1'b0;
            err_ovr       <= 1'b0;
            err_abort     <= 1'b0;
            words_written <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (en && !hold) begin
                        state         <= StAddr;
                        byte_cnt      <= '0;
                        sum           <= '0;
                        abort_pend    <= 1'b0;
                        words_written <= '0;
                        err_resp      <= 1'b0;
                        err_csum      <= 1'b0;
                        err_ovr       <= 1'b0;
                        err_abort     <= 1'b0;
                    end
                end
                StAddr: begin
                    if (!en) begin
                        state     <= StIdle;
                        err_abort <= 1'b1;
                    end else if (in_valid) begin
                        sum        <= sum_next;
                        axi_awaddr <= addr_shift;
                        if (byte_cnt == ADDR_LAST) begin
                            byte_cnt <= '0;
                            state    <= StLen;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                StLen: begin
                    if (!en) begin
                        state     <= StIdle;
                        err_abort <= 1'b1;
                    end else if (in_valid) begin
                        sum       <= sum_next;
                        remaining <= len_shift;
                        if (byte_cnt == LEN_LAST) begin
                            byte_cnt <= '0;
                            state    <= (len_shift == '0) ? StCsum : StData;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                StData: begin
                    if (!en) begin
                        state     <= StIdle;
                        err_abort <= 1'b1;
                    end else if (in_valid) begin
                        sum     <= sum_next;
                        data_sr <= data_shift;
                        if (byte_cnt == DATA_LAST) begin
                            byte_cnt    <= '0;
                            axi_wdata   <= data_shift;
                            axi_awvalid <= 1'b1;
                            axi_wvalid  <= 1'b1;
                            aw_done     <= 1'b0;
                            w_done      <= 1'b0;
                            state       <= StWrite;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                StWrite: begin
                    // An abort here is deferred until the B response retires the write.
                    if (!en) abort_pend <= 1'b1;
                    if (in_valid) err_ovr <= 1'b1;
                    if (axi_awvalid && axi_awready) begin
                        axi_awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (axi_wvalid && axi_wready) begin
                        axi_wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    if (aw_ok && w_ok) begin
                        axi_bready <= 1'b1;
                        state      <= StResp;
                    end
                end
                StResp: begin
                    if (!en) abort_pend <= 1'b1;
                    if (in_valid) err_ovr <= 1'b1;
                    if (axi_bvalid && axi_bready) begin
                        axi_bready    <= 1'b0;
                        if (axi_bresp != 2'b00) err_resp <= 1'b1;
                        words_written <= words_written + 32'd1;
                        axi_awaddr    <= axi_awaddr + ADDR_STEP;
                        remaining     <= rem_dec;
                        if (!en || abort_pend) begin
                            state     <= StIdle;
                            err_abort <= 1'b1;
                        end else if (rem_dec == '0) begin
                            state <= StCsum;
                        end else begin
                            state <= StData;
                        end
                    end
                end
                StCsum: begin
                    if (!en) begin
                        state     <= StIdle;
                        err_abort <= 1'b1;
                    end else if (in_valid) begin
                        // Sum over the whole frame, checksum byte included, must be zero.
                        if (sum_next != 8'h00) err_csum <= 1'b1;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    if (in_valid) err_ovr <= 1'b1;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_progloader_axi_burst.sv
module tb_progloader_axi_burst;

    logic        clk = 1'b0;
    logic        rst;
    logic        en32, en64, hold, in_valid;
    logic [7:0]  in_byte;
    logic        awready, wready, bvalid;
    logic [1:0]  bresp;

    logic [31:0] awaddr32, wdata32, ww32;
    logic [3:0]  wstrb32;
    logic        awvalid32, wvalid32, bready32, busy32, done32;
    logic        er32, ec32, eo32, ea32;

    logic [31:0] awaddr64, ww64;
    logic [63:0] wdata64;
    logic [7:0]  wstrb64;
    logic        awvalid64, wvalid64, bready64, busy64, done64;
    logic        er64, ec64, eo64, ea64;

    always #5 clk = ~clk;

    progloader_axi_burst #(.ADDR_W(32), .DATA_WIDTH(32), .LEN_BYTES(2)) dut32 (
        .clk(clk), .rst(rst), .en(en32), .hold(hold), .in_valid(in_valid), .in_byte(in_byte),
        .axi_awaddr(awaddr32), .axi_awvalid(awvalid32), .axi_awready(awready),
        .axi_wdata(wdata32), .axi_wstrb(wstrb32), .axi_wvalid(wvalid32), .axi_wready(wready),
        .axi_bready(bready32), .axi_bvalid(bvalid), .axi_bresp(bresp),
        .busy(busy32), .done(done32), .err_resp(er32), .err_csum(ec32), .err_ovr(eo32),
        .err_abort(ea32), .words_written(ww32)
    );

    progloader_axi_burst #(.ADDR_W(32), .DATA_WIDTH(64), .LEN_BYTES(2)) dut64 (
        .clk(clk), .rst(rst), .en(en64), .hold(hold), .in_valid(in_valid), .in_byte(in_byte),
        .axi_awaddr(awaddr64), .axi_awvalid(awvalid64), .axi_awready(awready),
        .axi_wdata(wdata64), .axi_wstrb(wstrb64), .axi_wvalid(wvalid64), .axi_wready(wready),
        .axi_bready(bready64), .axi_bvalid(bvalid), .axi_bresp(bresp),
        .busy(busy64), .done(done64), .err_resp(er64), .err_csum(ec64), .err_ovr(eo64),
        .err_abort(ea64), .words_written(ww64)
    );

    // Transaction logs for both instances
    logic [31:0] aw_log[64];
    logic [31:0] w_log[64];
    logic [31:0] aw64_log[16];
    logic [63:0] w64_log[16];
    int aw_n = 0, w_n = 0, b_n = 0, done_n = 0, aw64_n = 0, w64_n = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if (awvalid32 && awready) begin aw_log[aw_n] <= awaddr32; aw_n <= aw_n + 1; end
            if (wvalid32 && wready) begin w_log[w_n] <= wdata32; w_n <= w_n + 1; end
            if (bvalid && bready32) b_n <= b_n + 1;
            if (done32) done_n <= done_n + 1;
            if (awvalid64 && awready) begin aw64_log[aw64_n] <= awaddr64; aw64_n <= aw64_n + 1; end
            if (wvalid64 && wready) begin w64_log[w64_n] <= wdata64; w64_n <= w64_n + 1; end
        end
    end

    int passed = 0;
    int total = 0;
    logic [7:0] tx_sum;
    bit use64 = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte_fast(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        tx_sum   = tx_sum + b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_byte_fast(b);
        repeat (3) tick();
    endtask

    task automatic send_word(input logic [63:0] w, input int nbytes);
        for (int i = 0; i < nbytes; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic start_frame(input logic [31:0] addr, input logic [15:0] n);
        if (use64) en64 = 1'b1;
        else en32 = 1'b1;
        tick();
        tx_sum = 8'h00;
        for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic end_frame(input bit corrupt);
        logic [7:0] c;
        c = corrupt ? 8'h00 : 8'h00 - tx_sum;
        send_byte_fast(c);
        en32 = 1'b0;
        en64 = 1'b0;
        repeat (2) tick();
    endtask

    int ab, wb, bb, db;

    initial begin
        rst = 1'b1; en32 = 1'b0; en64 = 1'b0; hold = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00; tx_sum = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_busy", busy32, 1'b0);
        check("rst_valids", {awvalid32, wvalid32, bready32, done32}, 4'b0000);
        check("rst_errs", {er32, ec32, eo32, ea32}, 4'b0000);
        check("rst_addr_data_ww", {awaddr32, wdata32, ww32}, 96'h0);
        check("rst_wstrb", {wstrb64, wstrb32}, 12'hFFF);

        // Basic frame
        ab = aw_n; wb = w_n; db = done_n;
        start_frame(32'h0000_1000, 16'd2);
        send_word(64'h1122_3344, 4);
        send_word(64'h5566_7788, 4);
        end_frame(1'b0);
        check("basic_aw0", aw_log[ab], 32'h0000_1000);
        check("basic_aw1", aw_log[ab+1], 32'h0000_1004);
        check("basic_w0", w_log[wb], 32'h1122_3344);
        check("basic_w1", w_log[wb+1], 32'h5566_7788);
        check("basic_done", done_n - db, 1);
        check("basic_errs", {er32, ec32, eo32, ea32}, 4'b0000);
        check("basic_ww", ww32, 32'd2);
        check("basic_idle", busy32, 1'b0);

        // Backpressure
        ab = aw_n; wb = w_n;
        awready = 1'b0; wready = 1'b0;
        start_frame(32'h0000_2000, 16'd2);
        send_byte(8'hA0); send_byte(8'hA1); send_byte(8'hA2); send_byte_fast(8'hA3);
        check("bp0_valids_up", {awvalid32, wvalid32, bready32}, 3'b110);
        awready = 1'b1; tick(); awready = 1'b0;
        check("bp0_aw_drop", {awvalid32, wvalid32, bready32}, 3'b010);
        tick(); tick();
        check("bp0_w_hold", {awvalid32, wvalid32, bready32}, 3'b010);
        wready = 1'b1; tick(); wready = 1'b0;
        check("bp0_w_drop_bready", {awvalid32, wvalid32, bready32}, 3'b001);
        tick();
        check("bp0_resp", {bready32, ww32}, {1'b0, 32'd1});
        send_byte(8'hB0); send_byte(8'hB1); send_byte(8'hB2); send_byte_fast(8'hB3);
        wready = 1'b1; tick(); wready = 1'b0;
        check("bp1_w_drop", {awvalid32, wvalid32, bready32}, 3'b100);
        repeat (4) tick();
        check("bp1_addr_stable", awaddr32, 32'h0000_2004);
        awready = 1'b1; tick();
        check("bp1_aw_drop_bready", {awvalid32, wvalid32, bready32}, 3'b001);
        wready = 1'b1;
        tick();
        end_frame(1'b0);
        check("bp_aw", {aw_log[ab], aw_log[ab+1]}, {32'h0000_2000, 32'h0000_2004});
        check("bp_w", {w_log[wb], w_log[wb+1]}, {32'hA3A2_A1A0, 32'hB3B2_B1B0});
        check("bp_errs_ww", {er32, ec32, eo32, ea32, ww32}, {4'b0000, 32'd2});

        // bresp error on the middle word of three
        wb = w_n;
        start_frame(32'h0000_3000, 16'd3);
        send_word(64'h0000_0001, 4);
        bresp = 2'b10;
        send_word(64'h0000_0002, 4);
        bresp = 2'b00;
        send_word(64'h0000_0003, 4);
        end_frame(1'b0);
        check("bresp_flags", {er32, ec32, eo32, ea32}, 4'b1000);
        check("bresp_ww", ww32, 32'd3);
        check("bresp_w2", w_log[wb+2], 32'h0000_0003);

        // Corrupt checksum
        db = done_n;
        start_frame(32'h0000_4000, 16'd1);
        send_word(64'hDEAD_BEEF, 4);
        end_frame(1'b1);
        check("csum_flags", {er32, ec32, eo32, ea32}, 4'b0100);
        check("csum_done", done_n - db, 1);

        // N = 0
        ab = aw_n; db = done_n;
        start_frame(32'h0000_5000, 16'd0);
        end_frame(1'b0);
        check("n0_no_aw", aw_n - ab, 0);
        check("n0_done", done_n - db, 1);
        check("n0_ww_errs", {ww32, er32, ec32, eo32, ea32}, {32'd0, 4'b0000});

        // Address wrap
        ab = aw_n;
        start_frame(32'hFFFF_FFFC, 16'd2);
        send_word(64'h0BAD_F00D, 4);
        send_word(64'h600D_CAFE, 4);
        end_frame(1'b0);
        check("wrap_aw", {aw_log[ab], aw_log[ab+1]}, {32'hFFFF_FFFC, 32'h0000_0000});

        // Abort during DATA
        ab = aw_n; db = done_n;
        start_frame(32'h0000_6000, 16'd1);
        send_byte(8'h12); send_byte(8'h34);
        en32 = 1'b0;
        tick();
        check("abort_data_idle", {busy32, ea32}, 2'b01);
        repeat (8) tick();
        check("abort_data_no_aw_done", {aw_n - ab, done_n - db}, 64'h0);

        // Abort while awvalid is high
        ab = aw_n; bb = b_n; db = done_n;
        awready = 1'b0; wready = 1'b0;
        start_frame(32'h0000_7000, 16'd1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte_fast(8'h04);
        check("abort_wr_awvalid", awvalid32, 1'b1);
        en32 = 1'b0;
        tick();
        check("abort_wr_still_busy", {busy32, ea32}, 2'b10);
        awready = 1'b1; wready = 1'b1;
        tick(); tick();
        check("abort_wr_idle", {busy32, ea32}, 2'b01);
        check("abort_wr_txn", {aw_log[ab], 32'(b_n - bb), 32'(done_n - db)},
              {32'h0000_7000, 32'd1, 32'd0});

        // rst while in RESP
        bvalid = 1'b0;
        start_frame(32'h0000_8000, 16'd1);
        send_word(64'h5A5A_A5A5, 4);
        check("rst_resp_pre", {busy32, bready32}, 2'b11);
        en32 = 1'b0; rst = 1'b1;
        tick();
        check("rst_resp_ctrl", {busy32, bready32, awvalid32, wvalid32, done32}, 5'b00000);
        check("rst_resp_data", {awaddr32, wdata32, ww32}, 96'h0);
        rst = 1'b0; bvalid = 1'b1;
        tick();

        // hold blocks frame start
        ab = aw_n; wb = w_n;
        hold = 1'b1; en32 = 1'b1;
        repeat (3) tick();
        check("hold_idle", busy32, 1'b0);
        send_byte(8'hAA);
        check("hold_ignored", {busy32, eo32}, 2'b00);
        hold = 1'b0;
        start_frame(32'h0000_9000, 16'd1);
        send_word(64'hCAFE_F00D, 4);
        end_frame(1'b0);
        check("hold_after_frame", {aw_log[ab], w_log[wb]}, {32'h0000_9000, 32'hCAFE_F00D});
        check("hold_after_status", {ww32, er32, ec32, eo32, ea32}, {32'd1, 4'b0000});

        // 64-bit build
        use64 = 1'b1;
        start_frame(32'h0000_0100, 16'd2);
        send_word(64'h0123_4567_89AB_CDEF, 8);
        send_word(64'h1122_3344_5566_7788, 8);
        end_frame(1'b0);
        use64 = 1'b0;
        check("w64_aw", {aw64_log[0], aw64_log[1]}, {32'h0000_0100, 32'h0000_0108});
        check("w64_w0", w64_log[0], 64'h0123_4567_89AB_CDEF);
        check("w64_w1", w64_log[1], 64'h1122_3344_5566_7788);
        check("w64_status", {ww64, er64, ec64, eo64, ea64, busy64}, {32'd2, 5'b00000});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/progloader_axi_burst.md
# progloader_axi_burst

Parametrised program loader that receives a framed byte stream from the debug UART receiver and writes it into memory over an AXI4-Lite write channel. It replaces the fixed 32-bit, one-word-per-frame loader. One frame carries a base address, a word count, N data words and a checksum. Data width and address width are generic, and AXI response errors, checksum failures, overruns and aborts are reported. It sits between the UART receiver and the instruction/data memory interconnect, and is held off while the core is processing.

## Interface
- ADDR_W, 32: AXI address width; multiple of 8, 8..64.
- DATA_WIDTH, 32: AXI data width; 32, 64 or 128.
- LEN_BYTES, 2: width of the word-count field in bytes (1..4).
- Reset: rst, synchronous, active-high; clock clk. All logic is on posedge clk.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  loader enable (reprogram mode).
- hold  in  1  core busy; a new frame is not started while high.
- in_valid  in  1  one-cycle strobe; in_byte is valid.
- in_byte  in  8  received byte.
- axi_awaddr  out  ADDR_W  write address.
- axi_awvalid  out  1  address valid.
- axi_awready  in  1  address ready.
- axi_wdata  out  DATA_WIDTH  write data.
- axi_wstrb  out  DATA_WIDTH/8  tied all ones.
- axi_wvalid  out  1  data valid.
- axi_wready  in  1  data ready.
- axi_bready  out  1  response ready.
- axi_bvalid  in  1  response valid.
- axi_bresp  in  2  response code.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at frame end.
- err_resp, err_csum, err_ovr, err_abort  out  1 each  sticky status flags.
- words_written  out  32  count of words written in the current or last frame.

## Operation
- Frame format, all fields LSB byte first:
  - ADDR_W/8 address bytes.
  - LEN_BYTES count bytes, giving N.
  - N words of DATA_WIDTH/8 bytes each.
  - 1 checksum byte.
- States: IDLE, ADDR, LEN, DATA, WRITE, RESP, CSUM, DONE. A byte counter tracks position within a field.
- IDLE -> ADDR when en && !hold. On this transition all err_* flags, the running sum and words_written are cleared.
- ADDR: shift bytes into an address register. After ADDR_W/8 bytes, go to LEN.
- LEN: collect N. After LEN_BYTES bytes, go to CSUM if N==0, else DATA.
- DATA: assemble a word. After DATA_WIDTH/8 bytes, load axi_wdata, assert awvalid and wvalid, and go to WRITE.
- WRITE: awvalid drops on the cycle after its handshake (awvalid&&awready); wvalid likewise. Both channels are independent and their handshakes may occur in either order or in the same cycle. Once both are complete, assert bready and go to RESP.
- RESP: wait for bvalid. Then:
  - drop bready;
  - if bresp != 0, set err_resp;
  - words_written += 1;
  - awaddr += DATA_WIDTH/8, wrapping modulo 2^ADDR_W;
  - remaining -= 1;
  - go to CSUM if remaining == 0, else DATA.
- CSUM: take one byte. The 8-bit sum of every frame byte, including the checksum byte, must equal 0x00; otherwise set err_csum. Go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Bytes arriving in IDLE, WRITE, RESP or DONE are dropped. Such a byte sets err_ovr when busy=1; it is silently ignored in IDLE.
- en deasserted in ADDR, LEN, DATA or CSUM: go to IDLE next cycle, set err_abort, no done pulse.
- en deasserted in WRITE or RESP: the outstanding AXI transaction completes, then the block goes to IDLE with err_abort set and no done pulse.
- hold only gates the IDLE exit. It has no effect mid-frame.

## Timing
- Reset values:
  - state = IDLE.
  - axi_awvalid, axi_wvalid, axi_bready, done, busy = 0.
  - all err_* = 0; words_written = 0; axi_awaddr = 0; axi_wdata = 0.
- rst mid-frame: the next cycle is IDLE with all outputs at reset values, even with an AXI handshake outstanding.
- The last data byte in DATA produces awvalid/wvalid high on the next cycle.
- With awready, wready and bvalid tied high, each word costs DATA_WIDTH/8 byte strobes plus 3 cycles:
  - WRITE, 1 cycle (both handshakes);
  - RESP, 1 cycle (bvalid seen while bready=1);
  - 1 cycle return to DATA.
- awvalid and wvalid never rise outside the DATA->WRITE transition. awaddr and wdata are stable while the corresponding valid is high.
- in_valid spacing of at least 4 cycles is guaranteed by the UART receiver, so no byte is lost at steady state.

## Test plan
- Basic frame, ready signals tied high: address 0x00001000, N=2, words 0x11223344 and 0x55667788, correct checksum -> two writes at 0x1000 and 0x1004 with the matching wdata; done pulses once; all err flags = 0; words_written = 2.
- Backpressure: wready raised 3 cycles after awready on word 0, awready raised 5 cycles after wready on word 1 -> each valid drops exactly one cycle after its own handshake; bready rises only after both handshakes.
- Errors: bresp=2'b10 on word 1 of 3 -> err_resp=1 and all 3 words written. Corrupt checksum (0x00 instead of the correct value) -> err_csum=1, done still pulses.
- Edge frames: N=0 -> no AXI activity, done pulses. Base address 0xFFFFFFFC with N=2 -> writes at 0xFFFFFFFC, then 0x00000000.
- Abort: drop en after 2 data bytes -> IDLE, err_abort=1, no write. Drop en while awvalid is high -> the write completes with a B handshake, then IDLE, err_abort=1.
- Control: rst asserted in RESP -> outputs at reset values next cycle. hold=1 with en=1 -> busy stays 0 and bytes are ignored; after hold falls, a frame loads normally. DATA_WIDTH=64 build -> an 8-byte word assembles LSB first and the address increments by 8.
